// File: rtl/sipo_byte_packer.sv
// sipo_byte_packer: packs a framed serial stream into bytes and re-times the shifter delay select to byte boundaries.
// Define SIPO_BYTE_PACKER_PARITY_EN to add a trailing even-parity bit per byte and the parity_err pulse.
module sipo_byte_packer #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       frame_start,
    input  logic       stop,
    input  logic [1:0] sel_in,
    input  logic       sel_load,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [1:0] sel_out,
    output logic [3:0] bit_cnt,
    output logic       frame_err,
    output logic       parity_err
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d, byte_q, byte_d, sr_sh;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] selp_q, selp_d, selo_q, selo_d;
    logic       bv_q, bv_d, fe_q, fe_d, pe_q, pe_d, data_bit;

`ifdef SIPO_BYTE_PACKER_PARITY_EN
    localparam logic [3:0] LAST = 4'd8;
    // the ninth accepted bit is parity and never enters the shift register
    assign data_bit = cnt_q != LAST;
`else
    localparam logic [3:0] LAST = 4'd7;
    assign data_bit = 1'b1;
`endif

    assign sr_sh = (MSB_FIRST != 0) ? {sr_q[6:0], bit_in} : {bit_in, sr_q[7:1]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        selp_d  = selp_q;
        selo_d  = selo_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (frame_start) begin
            state_d = SHIFT;
            fe_d    = (state_q == SHIFT) && (cnt_q != '0);
            sr_d    = bit_valid ? sr_sh : sr_q;
            cnt_d   = {3'b000, bit_valid};
            selp_d  = sel_load ? sel_in : selp_q;
            selo_d  = (sel_load && state_q == IDLE) ? sel_in : selo_q;
        end else if (state_q == IDLE) begin
            selp_d = sel_load ? sel_in : selp_q;
            selo_d = sel_load ? sel_in : selo_q;
        end else begin
            selp_d = sel_load ? sel_in : selp_q;
            if (bit_valid) begin
                sr_d  = data_bit ? sr_sh : sr_q;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    cnt_d  = '0;
                    bv_d   = 1'b1;
                    byte_d = data_bit ? sr_sh : sr_q;
                    selo_d = sel_load ? sel_in : selp_q;
`ifdef SIPO_BYTE_PACKER_PARITY_EN
                    pe_d   = ^{sr_q, bit_in};
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            byte_q  <= '0;
            cnt_q   <= '0;
            selp_q  <= '0;
            selo_q  <= '0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            selp_q  <= selp_d;
            selo_q  <= selo_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = bv_q;
    assign sel_out    = selo_q;
    assign bit_cnt    = cnt_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
endmodule

// File: tb/tb_sipo_byte_packer.sv
// tb_sipo_byte_packer: scoreboard bench driving MSB-first and LSB-first packers with one shared stream.
module tb_sipo_byte_packer;
`ifdef SIPO_BYTE_PACKER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, frame_start = 1'b0, stop = 1'b0, sel_load = 1'b0;
    logic [1:0] sel_in = 2'b00;
    logic [7:0] bo1, bo0;
    logic [1:0] so1, so0;
    logic [3:0] bc1, bc0;
    logic       bv1, bv0, fe1, fe0, pe1, pe0;

    int n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct {
        int b1;
        int b0;
        int par;
        int cyc;
    } exp_t;

    exp_t bq[$];
    int   fq[$];

    logic       m_in = 1'b0;
    int         m_bits[$];
    logic [1:0] m_sp = 2'b00, m_so = 2'b00;
    int         m_b1 = 0, m_b0 = 0;

    sipo_byte_packer #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
        .stop(stop), .sel_in(sel_in), .sel_load(sel_load), .byte_out(bo1), .byte_valid(bv1),
        .sel_out(so1), .bit_cnt(bc1), .frame_err(fe1), .parity_err(pe1)
    );

    sipo_byte_packer #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
        .stop(stop), .sel_in(sel_in), .sel_load(sel_load), .byte_out(bo0), .byte_valid(bv0),
        .sel_out(so0), .bit_cnt(bc0), .frame_err(fe0), .parity_err(pe0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b, input logic fs,
                        input logic st, input logic sl, input logic [1:0] si);
        int   v1, v0, p;
        exp_t e;
        rst = r; bit_valid = v; bit_in = b; frame_start = fs; stop = st; sel_load = sl; sel_in = si;
        @(posedge clk);
        #1;
        if (r) begin
            m_in = 1'b0; m_bits.delete(); m_sp = 2'b00; m_so = 2'b00; m_b1 = 0; m_b0 = 0;
        end else if (st) begin
            m_in = 1'b0; m_bits.delete();
        end else if (!m_in) begin
            if (sl) begin m_sp = si; m_so = si; end
            if (fs) begin
                m_in = 1'b1;
                if (v) m_bits.push_back(int'(b));
            end
        end else begin
            if (sl) m_sp = si;
            if (fs) begin
                if (m_bits.size() != 0) fq.push_back(cyc);
                m_bits.delete();
                if (v) m_bits.push_back(int'(b));
            end else if (v) begin
                m_bits.push_back(int'(b));
                if (m_bits.size() == NB) begin
                    v1 = 0; v0 = 0; p = 0;
                    for (int i = 0; i < 8; i++) begin
                        v1 += m_bits[i] << (7 - i);
                        v0 += m_bits[i] << i;
                    end
                    for (int i = 0; i < NB; i++) p ^= m_bits[i];
                    m_b1 = v1; m_b0 = v0; m_so = m_sp;
                    e.b1 = v1; e.b0 = v0; e.par = (NB == 9) ? p : 0; e.cyc = cyc;
                    bq.push_back(e);
                    m_bits.delete();
                end
            end
        end
        chk("bit_cnt msb", int'(bc1), m_bits.size());
        chk("bit_cnt lsb", int'(bc0), m_bits.size());
        chk("sel_out msb", int'(so1), int'(m_so));
        chk("sel_out lsb", int'(so0), int'(m_so));
        chk("byte_out held msb", int'(bo1), m_b1);
        chk("byte_out held lsb", int'(bo0), m_b0);
    endtask

    task automatic send(input logic [7:0] v, input logic fs, input int sl_at, input logic [1:0] si, input logic pbad);
        logic bb;
        for (int i = 0; i < NB; i++) begin
            if (i < 8) bb = v[7 - i];
            else bb = (^v) ^ pbad;
            step(1'b0, 1'b1, bb, fs && i == 0, 1'b0, i == sl_at, si);
        end
    endtask

    initial begin
        exp_t e;
        int   f;
        forever begin
            @(negedge clk);
            if (bv1 === 1'b1 || bv0 === 1'b1 || pe1 === 1'b1 || pe0 === 1'b1) begin
                if (bq.size() == 0) begin
                    chk("spurious byte_valid/parity_err", int'({bv1, bv0, pe1, pe0}), 0);
                end else begin
                    e = bq.pop_front();
                    chk("byte_valid cycle", cyc, e.cyc);
                    chk("byte_valid msb", int'(bv1), 1);
                    chk("byte_valid lsb", int'(bv0), 1);
                    chk("byte msb", int'(bo1), e.b1);
                    chk("byte lsb", int'(bo0), e.b0);
                    chk("parity_err msb", int'(pe1), e.par);
                    chk("parity_err lsb", int'(pe0), e.par);
                end
            end
            if (fe1 === 1'b1 || fe0 === 1'b1) begin
                if (fq.size() == 0) begin
                    chk("spurious frame_err", int'({fe1, fe0}), 0);
                end else begin
                    f = fq.pop_front();
                    chk("frame_err cycle", cyc, f);
                    chk("frame_err pair", int'({fe1, fe0}), 3);
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 0, 0, 0, 2'b00);
        send(8'hC1, 1'b1, -1, 2'b00, 1'b0);
        send(8'hFF, 1'b0, -1, 2'b00, 1'b0);
        step(0, 0, 0, 0, 0, 0, 2'b00);
        send(8'h3C, 1'b0, 3, 2'b11, 1'b0);
        step(0, 0, 0, 0, 1, 0, 2'b00);
        step(0, 0, 0, 0, 0, 1, 2'b10);
        step(0, 0, 0, 0, 0, 0, 2'b00);
        for (int i = 0; i < 5; i++) step(0, 1, 1'(($urandom >> 3) & 1), i == 0, 0, 0, 2'b00);
        send(8'h5A, 1'b1, -1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 1, 1'(i & 1), i == 0, 0, 0, 2'b00);
        step(0, 1, 1, 1, 1, 0, 2'b00);
        step(0, 0, 0, 0, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) step(0, 1, 1'b1, i == 0, 0, 0, 2'b00);
        step(1, 1, 1, 0, 0, 0, 2'b00);
        step(0, 0, 0, 0, 0, 0, 2'b00);
`ifdef SIPO_BYTE_PACKER_PARITY_EN
        send(8'hC1, 1'b1, -1, 2'b00, 1'b0);
        send(8'hC1, 1'b0, -1, 2'b00, 1'b1);
`endif
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 999) < 4, $urandom_range(0, 99) < 75, 1'($urandom & 1),
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 10, 2'($urandom & 3));
        end
        step(0, 0, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 0, 0, 0, 2'b00);
        chk("byte scoreboard drained", bq.size(), 0);
        chk("frame_err scoreboard drained", fq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_byte_packer.md
Name: sipo_byte_packer

Overview:
- Serial-in/parallel-out packer that sits directly upstream of the 8-bit selectable-delay shifter.
- Assembles a framed serial bit stream into bytes and drives the shifter's 8-bit data input.
- Also drives the shifter's 2-bit delay select, re-timed so the select only changes on byte boundaries.
- Bytes are emitted as back-to-back 1-cycle valid strobes; byte_out holds its value between bytes.

Parameters:
- MSB_FIRST, 1, 1: first received bit of a byte lands in byte_out[7]; 0: it lands in byte_out[0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- bit_in  input  1  serial data bit, sampled when bit_valid=1
- bit_valid  input  1  bit_in qualifier
- frame_start  input  1  marks the current cycle as the byte-alignment point (next accepted bit = bit 0)
- stop  input  1  return to IDLE and discard any partial byte, no error
- sel_in  input  2  requested delay select
- sel_load  input  1  capture sel_in into the pending-select register
- byte_out  output  8  assembled byte, feeds the shifter data input; held between bytes
- byte_valid  output  1  1-cycle pulse when byte_out updates
- sel_out  output  2  delay select, feeds the shifter select input
- bit_cnt  output  4  data bits accepted in the current byte (0..7, or 0..8 with parity)
- frame_err  output  1  1-cycle pulse when a partial byte is discarded by frame_start
- parity_err  output  1  1-cycle pulse with byte_valid on parity mismatch (feature only)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE
  - shift register, byte_out, bit_cnt, sel_pending, sel_out all = 0
  - byte_valid, frame_err, parity_err = 0
  - rst overrides every other input, including mid-byte; the partial byte is lost with no error pulse.
- States: IDLE and SHIFT.
- IDLE:
  - bit_valid is ignored unless frame_start=1 in the same cycle.
  - frame_start=1 -> SHIFT. If bit_valid is also 1, that bit is bit 0 and bit_cnt=1; otherwise bit_cnt=0.
  - sel_load=1 -> sel_pending and sel_out both take sel_in on the next edge.
- SHIFT, each bit_valid=1:
  - MSB_FIRST=1: shift left, inserting at the LSB. MSB_FIRST=0: shift right, inserting at the MSB.
  - bit_cnt increments by 1.
- Byte completion (8th data bit accepted, bit_cnt=7 and bit_valid=1):
  - On that same edge: byte_out <= assembled byte, byte_valid=1 for exactly the following cycle, bit_cnt <= 0.
  - State stays SHIFT, so continuous bytes need no new frame_start.
  - Latency: last bit sampled at edge N -> byte_out/byte_valid visible from edge N until edge N+1.
  - Back-to-back bits give at most one byte_valid per 8 cycles.
- Select timing:
  - sel_load in SHIFT updates sel_pending only.
  - sel_out <= sel_pending on the edge a byte completes.
  - sel_load in the completion cycle takes effect on that same byte: sel_in goes straight to sel_out.
- frame_start in SHIFT:
  - bit_cnt != 0: partial byte discarded, frame_err pulses for 1 cycle, realign. The current bit (if bit_valid) becomes bit 0.
  - bit_cnt == 0: realign silently, no error.
  - frame_start together with the 8th bit: frame_start wins. No byte is emitted, frame_err=1, the bit becomes bit 0 of the new byte.
- stop=1 (any state):
  - next state IDLE, bit_cnt=0, no pulses, byte_out held.
  - stop has priority over frame_start.
  - sel_pending is retained.
- byte_valid, frame_err and parity_err are never asserted in the cycle directly after reset.

Optional Feature:
- Macro: SIPO_BYTE_PACKER_PARITY_EN.
- Defined:
  - Each byte is 8 data bits followed by 1 even-parity bit; bit_cnt runs 0..8.
  - Completion happens on the 9th accepted bit, and byte_out excludes the parity bit.
  - parity_err pulses with byte_valid when the XOR of the 8 data bits and the parity bit is 1. The byte is still delivered.
  - frame_start with bit_cnt in 1..8 raises frame_err.
- Undefined: 8-bit bytes as described above; parity_err is tied to 0.

Test Plan:
- Reset then MSB_FIRST=1: frame_start+bit_valid with bits 1,1,0,0,0,0,0,1 on consecutive cycles -> byte_out=0xC1, byte_valid high exactly 1 cycle after the 8th bit's edge, bit_cnt back to 0.
- MSB_FIRST=0, same stream -> byte_out=0x83; a second byte 0xFF streamed immediately -> second byte_valid exactly 8 cycles after the first, no frame_start needed.
- Select timing: sel_load=1 with sel_in=2'b11 at bit 3 of a byte -> sel_out stays 0 until the byte_valid edge, then 2'b11. Repeat in IDLE -> sel_out=2'b10 one cycle after sel_load.
- Realign: after 5 bits assert frame_start+bit_valid -> frame_err 1-cycle pulse, no byte_valid. The next 8 bits (including this one) 0x5A -> byte_out=0x5A.
- stop after 3 bits, then rst asserted mid-byte in a second pass -> no byte_valid/frame_err. byte_out holds the previous value after stop; all outputs 0 the cycle after rst.
- With SIPO_BYTE_PACKER_PARITY_EN: data 0xC1 + parity 1 -> byte_out=0xC1, parity_err=0. Same data + parity 0 -> byte_out=0xC1, parity_err=1 with byte_valid.
